// File: rtl/peripheral_bfm_memory_wb.sv
// Wishbone B4 responder memory model: classic and incrementing-burst cycles, optional wait states.
// Define BFM_MEMORY_WB_ERR_EN to answer out-of-range addresses with wb_err_o instead of aliasing.
module peripheral_bfm_memory_wb #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int MEMORY_SIZE = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);
  localparam int NB    = DW / 8;
  localparam int BW    = $clog2(NB);
  localparam int MW    = $clog2(MEMORY_SIZE);
  localparam int IW    = MW - BW;
  localparam int WORDS = MEMORY_SIZE / NB;
  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BURST} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d, next_addr, load_addr;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack_q, ack_d, err_q, err_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [DW-1:0]   mem [WORDS];
  logic [IW-1:0]   cur_idx, inc_idx, wrap_mask, load_idx;
  logic            req, beat_done, mem_we, load_en, load_oor;
  logic            unused_addr;

  // A beat completes on a clock edge where wb_ack_o, wb_cyc_i and wb_stb_i are all 1;
  // only a completed beat writes memory or advances the burst address.
  assign req         = wb_cyc_i & wb_stb_i;
  assign beat_done   = ack_q & req;
  assign cur_idx     = addr_q[MW-1:BW];
  assign inc_idx     = cur_idx + IW'(1);
  assign load_idx    = load_addr[MW-1:BW];
  assign unused_addr = ^addr_q;

  always_comb begin
    case (wb_bte_i)
      2'b01:   wrap_mask = IW'(3);
      2'b10:   wrap_mask = IW'(7);
      2'b11:   wrap_mask = IW'(15);
      default: wrap_mask = '1;
    endcase
    next_addr = addr_q;
    next_addr[MW-1:BW] = (cur_idx & ~wrap_mask) | (inc_idx & wrap_mask);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
      S_WAIT:  if (!wb_cyc_i) state_d = S_IDLE;
               else if (cnt_q == CNT_LAST) state_d = S_ACK;
      S_ACK:   if (err_q || !wb_cyc_i || wb_cti_i != 3'b010) state_d = S_IDLE;
               else state_d = S_BURST;
      S_BURST: if (!wb_cyc_i || (beat_done && wb_cti_i == 3'b111)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = dat_q;
    mem_we    = 1'b0;
    load_en   = 1'b0;
    load_addr = addr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d    = wb_adr_i;
          cnt_d     = '0;
          load_en   = (WAIT_CYCLES == 0);
          load_addr = wb_adr_i;
        end
      end
      S_WAIT: begin
        if (wb_cyc_i) begin
          cnt_d   = cnt_q + CW'(1);
          load_en = (cnt_q == CNT_LAST);
        end
      end
      S_ACK: begin
        mem_we = beat_done & wb_we_i;
        if (beat_done && wb_cti_i == 3'b010) begin
          addr_d    = next_addr;
          load_en   = 1'b1;
          load_addr = next_addr;
        end
      end
      S_BURST: begin
        mem_we = beat_done & wb_we_i;
        if (beat_done && wb_cti_i != 3'b111) begin
          addr_d    = next_addr;
          load_en   = 1'b1;
          load_addr = next_addr;
        end else if (req && !ack_q) begin
          // Resuming after a stb pause re-presents the beat that was not yet taken.
          load_en = 1'b1;
        end
      end
      default: ;
    endcase
`ifdef BFM_MEMORY_WB_ERR_EN
    load_oor = (load_addr >> MW) != '0;
`else
    load_oor = 1'b0;
`endif
    if (load_en) begin
      if (load_oor) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        dat_d = mem[load_idx];
      end
    end
  end

  // Memory has no reset so contents survive a reset pulse.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i && mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (wb_sel_i[b]) mem[cur_idx][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
      end
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
endmodule

// File: tb/tb_peripheral_bfm_memory_wb.sv
// Bench for peripheral_bfm_memory_wb: one instance with no wait states, one with two.
// A select bit routes the shared master signals to exactly one instance at a time.
module tb_peripheral_bfm_memory_wb;
  logic        clk = 1'b0;
  logic        m_rst = 1'b0;
  logic        which = 1'b0;
  logic [31:0] m_adr = '0, m_dat = '0;
  logic [3:0]  m_sel = '0;
  logic        m_we = 1'b0, m_cyc = 1'b0, m_stb = 1'b0;
  logic [2:0]  m_cti = '0;
  logic [1:0]  m_bte = '0;
  logic [31:0] dat0, dat2, s_dat;
  logic        ack0, err0, rty0, ack2, err2, rty2, s_ack, s_err;

  logic [31:0] exp_q[$];
  int          n_vec = 0, n_fail = 0;

  always #5 clk = ~clk;

  peripheral_bfm_memory_wb #(.DW(32), .AW(32), .MEMORY_SIZE(1024), .WAIT_CYCLES(0)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(m_rst), .wb_adr_i(m_adr), .wb_dat_i(m_dat), .wb_sel_i(m_sel),
    .wb_we_i(m_we), .wb_cyc_i(m_cyc & ~which), .wb_stb_i(m_stb & ~which), .wb_cti_i(m_cti),
    .wb_bte_i(m_bte), .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0));

  peripheral_bfm_memory_wb #(.DW(32), .AW(32), .MEMORY_SIZE(1024), .WAIT_CYCLES(2)) u_dut2 (
    .wb_clk_i(clk), .wb_rst_i(m_rst), .wb_adr_i(m_adr), .wb_dat_i(m_dat), .wb_sel_i(m_sel),
    .wb_we_i(m_we), .wb_cyc_i(m_cyc & which), .wb_stb_i(m_stb & which), .wb_cti_i(m_cti),
    .wb_bte_i(m_bte), .wb_dat_o(dat2), .wb_ack_o(ack2), .wb_err_o(err2), .wb_rty_o(rty2));

  assign s_dat = which ? dat2 : dat0;
  assign s_ack = which ? ack2 : ack0;
  assign s_err = which ? err2 : err0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_rst) check("ack_err_excl", {31'd0, (ack0 & err0) | (ack2 & err2)}, 32'd0);
  end

  task automatic wb_single(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [1:0] exp_resp, input string name);
    int lat;
    bit got;
    m_cyc = 1; m_stb = 1; m_we = we; m_adr = adr; m_dat = dat; m_sel = sel;
    m_cti = 3'b000; m_bte = 2'b00;
    lat = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (s_ack || s_err) got = 1;
    end
    if (!got) begin
      check({name, " timeout"}, 32'd0, 32'd1);
      if (!we && exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check({name, " resp"}, {30'd0, s_err, s_ack}, {30'd0, exp_resp});
      check({name, " lat"}, lat, which ? 32'd3 : 32'd1);
      if (!we) begin
        if (exp_q.size() == 0) check({name, " sb_empty"}, 32'd0, 32'd1);
        else check({name, " rdata"}, s_dat, exp_q.pop_front());
      end
      @(posedge clk); #1;
      check({name, " resp_drop"}, {31'd0, s_ack | s_err}, 32'd0);
    end
    m_cyc = 0; m_stb = 0; m_we = 0;
    @(posedge clk); #1;
  endtask

  task automatic wb_burst(input logic [31:0] adr, input logic [1:0] bte, input int nbeats,
                          input int pause_after, input int pause_len, input string name,
                          output int gap);
    int  beats, hold;
    bit  drop_next, in_pause;
    beats = 0; hold = 0; drop_next = 0; in_pause = 0; gap = 0;
    m_cyc = 1; m_stb = 1; m_we = 0; m_adr = adr; m_bte = bte;
    m_cti = (nbeats == 1) ? 3'b111 : 3'b010;
    for (int i = 0; i < 60 && beats < nbeats; i++) begin
      @(posedge clk); #1;
      if (drop_next) begin
        m_stb = 0; hold = pause_len; drop_next = 0; in_pause = 1;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) m_stb = 1;
      end
      if (in_pause && !s_ack) gap++;
      if (s_ack && m_stb) begin
        in_pause = 0;
        beats++;
        if (exp_q.size() == 0) check({name, " sb_empty"}, 32'd0, 32'd1);
        else check({name, " beat"}, s_dat, exp_q.pop_front());
        if (beats == pause_after) drop_next = 1;
        if (beats == nbeats) m_cti = 3'b111;
      end
    end
    if (beats < nbeats) begin
      check({name, " timeout"}, beats, nbeats);
      exp_q.delete();
    end
    @(posedge clk); #1;
    check({name, " tail_ack"}, {31'd0, s_ack}, 32'd0);
    m_cyc = 0; m_stb = 0; m_cti = 3'b000; m_bte = 2'b00;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    bit got;
    vt[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0};
    vt[1]  = '{1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 32'h010, 32'h000000AA, 4'h1, 32'h0};
    vt[3]  = '{1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADBEAA};
    vt[4]  = '{1'b1, 32'h014, 32'hA5A5A5A5, 4'hF, 32'h0};
    vt[5]  = '{1'b1, 32'h014, 32'h12340000, 4'hC, 32'h0};
    vt[6]  = '{1'b0, 32'h014, 32'h0,        4'hF, 32'h1234A5A5};
    vt[7]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0};
    vt[8]  = '{1'b0, 32'h3FC, 32'h0,        4'hF, 32'hCAFEF00D};
    vt[9]  = '{1'b1, 32'h010, 32'h1,        4'hF, 32'h0};
    vt[10] = '{1'b1, 32'h014, 32'h2,        4'hF, 32'h0};
    vt[11] = '{1'b1, 32'h018, 32'h3,        4'hF, 32'h0};
    vt[12] = '{1'b1, 32'h01C, 32'h4,        4'hF, 32'h0};
    vt[13] = '{1'b0, 32'h01C, 32'h0,        4'hF, 32'h4};
    vt[14] = '{1'b1, 32'h000, 32'h01020304, 4'hF, 32'h0};
    vt[15] = '{1'b0, 32'h000, 32'h0,        4'hF, 32'h01020304};

    repeat (3) @(posedge clk);
    #1;
    check("rst ack0", {31'd0, ack0}, 32'd0);
    check("rst err0", {31'd0, err0}, 32'd0);
    check("rst dat0", dat0, 32'd0);
    check("rst rty0", {31'd0, rty0}, 32'd0);
    check("rst ack2", {31'd0, ack2}, 32'd0);
    check("rst dat2", dat2, 32'd0);
    m_rst = 1'b1;
    @(posedge clk); #1;

    which = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!vt[i].we) exp_q.push_back(vt[i].exp);
      wb_single(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, 2'b01, $sformatf("vec%0d", i));
    end

    exp_q.push_back(32'd3); exp_q.push_back(32'd4);
    exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    wb_burst(32'h18, 2'b01, 4, 0, 0, "wrap4", gap);

`ifdef BFM_MEMORY_WB_ERR_EN
    wb_single(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 2'b10, "oor_wr");
    check("oor_wr dat_hold", dat0, 32'd2);
    exp_q.push_back(32'h01020304);
    wb_single(1'b0, 32'h000, 32'h0, 4'hF, 2'b01, "oor_nowrite");
    exp_q.push_back(32'h01020304);
    wb_single(1'b0, 32'h400, 32'h0, 4'hF, 2'b10, "oor_rd");
    exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'h01020304);
`else
    wb_single(1'b1, 32'h400, 32'h55AA55AA, 4'hF, 2'b01, "alias_wr");
    exp_q.push_back(32'h55AA55AA);
    wb_single(1'b0, 32'h000, 32'h0, 4'hF, 2'b01, "alias_rd0");
    exp_q.push_back(32'h55AA55AA);
    wb_single(1'b0, 32'h400, 32'h0, 4'hF, 2'b01, "alias_rd400");
    exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'h55AA55AA);
`endif
    wb_burst(32'h3FC, 2'b00, 2, 0, 0, "lin_modwrap", gap);

    which = 1'b1;
    for (int k = 0; k < 4; k++)
      wb_single(1'b1, 32'h20 + 32'(4 * k), 32'hA0000000 + 32'(k), 4'hF, 2'b01, $sformatf("w2_wr%0d", k));
    exp_q.push_back(32'hA0000000);
    wb_single(1'b0, 32'h20, 32'h0, 4'hF, 2'b01, "w2_rd");
    for (int k = 0; k < 4; k++) exp_q.push_back(32'hA0000000 + 32'(k));
    wb_burst(32'h20, 2'b00, 4, 2, 2, "w2_pause", gap);
    check("w2_pause gap", gap, 32'd2);

    which = 1'b0;
    wb_single(1'b1, 32'h40, 32'h600DCAFE, 4'hF, 2'b01, "pre_rst_wr");
    m_cyc = 1; m_stb = 1; m_we = 0; m_adr = 32'h44; m_cti = 3'b010; m_bte = 2'b00;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (ack0) got = 1;
    end
    check("midrst first_ack", {31'd0, got}, 32'd1);
    m_rst = 1'b0;
    @(posedge clk); #1;
    check("midrst ack", {31'd0, ack0}, 32'd0);
    check("midrst err", {31'd0, err0}, 32'd0);
    check("midrst dat", dat0, 32'd0);
    m_rst = 1'b1; m_cyc = 0; m_stb = 0; m_cti = 3'b000;
    @(posedge clk); #1;
    exp_q.push_back(32'h600DCAFE);
    wb_single(1'b0, 32'h40, 32'h0, 4'hF, 2'b01, "post_rst_rd40");
    exp_q.push_back(32'h1);
    wb_single(1'b0, 32'h10, 32'h0, 4'hF, 2'b01, "post_rst_rd10");
    check("final rty0", {31'd0, rty0}, 32'd0);
    check("final rty2", {31'd0, rty2}, 32'd0);
    check("sb drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/peripheral_bfm_memory_wb.md
PERIPHERAL_BFM_MEMORY_WB -- requirements
Module: peripheral_bfm_memory_wb

Interface
REQ-001 Parameters SHALL be, one per line, name / default / meaning:
- DW / 32 / data width, multiple of 8.
- AW / 32 / address width.
- MEMORY_SIZE / 1024 / memory size in bytes, power of two, at least 4*DW/8.
- WAIT_CYCLES / 0 / extra cycles inserted before the first ack of every access.
REQ-002 Ports SHALL be, one per line, name / direction / width / meaning:
- wb_clk_i / in / 1 / clock.
- wb_rst_i / in / 1 / reset.
- wb_adr_i / in / AW / byte address.
- wb_dat_i / in / DW / write data.
- wb_sel_i / in / DW/8 / byte-lane enables.
- wb_we_i / in / 1 / write enable.
- wb_cyc_i / in / 1 / cycle valid.
- wb_stb_i / in / 1 / strobe.
- wb_cti_i / in / 3 / cycle type.
- wb_bte_i / in / 2 / burst type.
- wb_dat_o / out / DW / read data.
- wb_ack_o / out / 1 / acknowledge.
- wb_err_o / out / 1 / error.
- wb_rty_o / out / 1 / retry, tied 0.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.
- Clock port: wb_clk_i.
- Reset port: wb_rst_i, where 0 = reset.

Function
REQ-004 The block SHALL be a Wishbone B4 responder (slave) memory model.
- Storage: MEMORY_SIZE/(DW/8) words.
- Word index: address bits [log2(MEMORY_SIZE)-1 : log2(DW/8)].
REQ-005 The FSM SHALL have four states: IDLE, WAIT, ACK, BURST.
REQ-006 IDLE SHALL be left on the first cycle where wb_cyc_i and wb_stb_i are both 1.
- Latches wb_adr_i into an internal address register.
- Goes to WAIT if WAIT_CYCLES > 0, otherwise to ACK.
REQ-007 WAIT SHALL count WAIT_CYCLES clocks, then go to ACK.
- If wb_cyc_i falls while in WAIT, go to IDLE with no ack.
REQ-008 ACK SHALL assert wb_ack_o (or wb_err_o) for exactly one cycle.
- Minimum access latency: 1 + WAIT_CYCLES cycles from stb to ack.
REQ-009 Classic cycles (wb_cti_i = 000 or 111) SHALL return to IDLE after ACK.
- The ack deasserts the cycle after it was asserted, even if wb_stb_i stays high.
REQ-010 Incrementing burst (wb_cti_i = 010 at the first ack) SHALL go to BURST.
- In BURST, wb_ack_o stays 1 every cycle that wb_stb_i is 1.
- Each acked beat advances the internal address by DW/8 bytes.
REQ-011 Burst address advance SHALL follow wb_bte_i.
- 00: linear.
- 01: wrap within an aligned 4-beat block.
- 10: wrap within an aligned 8-beat block.
- 11: wrap within an aligned 16-beat block.
- Linear bursts wrap modulo MEMORY_SIZE.
REQ-012 A BURST beat with wb_cti_i = 111 SHALL be acked, then the FSM goes to IDLE.
- If wb_cyc_i falls in BURST, go to IDLE immediately with no further ack.
REQ-013 If wb_stb_i drops in BURST with wb_cyc_i still 1, the block SHALL pause.
- wb_ack_o is 0 from the next cycle.
- The address holds.
- Acks resume one cycle after wb_stb_i returns to 1.
REQ-014 Writes SHALL update only the byte lanes whose wb_sel_i bit is 1, on the cycle wb_ack_o is 1.
REQ-015 Read data SHALL be registered.
- wb_dat_o holds the word at the current internal address in every cycle wb_ack_o is 1.
- In other cycles wb_dat_o holds its last value.
REQ-016 wb_ack_o and wb_err_o SHALL never both be 1 in the same cycle.
REQ-017 wb_rty_o SHALL be constant 0.

Reset
REQ-018 While wb_rst_i = 0 at a clock edge, the block SHALL reset its registers.
- FSM goes to IDLE.
- wb_ack_o, wb_err_o and wb_dat_o become 0.
- Wait counter and address register are cleared.
REQ-019 Reset SHALL NOT alter memory contents.
REQ-020 Reset asserted mid-burst SHALL abort the burst; the next access restarts from IDLE.

Configuration
REQ-021 Macro BFM_MEMORY_WB_ERR_EN SHALL control out-of-range handling.
- Defined: any beat with an address at or above MEMORY_SIZE is answered with wb_err_o = 1 instead of wb_ack_o; no write occurs; wb_dat_o is unchanged.
- Defined: an error beat ends the access; the FSM goes to IDLE.
- Not defined: the address is taken modulo MEMORY_SIZE and acked normally; wb_err_o is constant 0.

Verification
REQ-022 Classic write then read, WAIT_CYCLES=0:
- Write 0xDEADBEEF to 0x10 with sel 1111 -> ack 1 cycle after stb.
- Read 0x10 -> 0xDEADBEEF.
REQ-023 Byte-lane write:
- Write 0x000000AA to 0x10 with sel 0001 over 0xDEADBEEF -> read returns 0xDEADBEAA.
REQ-024 Wrap-4 read burst:
- 0x18, cti 010, bte 01, 4 beats, preloaded 0x10..0x1C = 1,2,3,4 -> data 3,4,1,2 on consecutive acks.
- Last beat cti 111; ack low the following cycle.
REQ-025 WAIT_CYCLES=2:
- Classic read -> ack exactly 3 cycles after stb.
- stb paused for 2 cycles mid linear burst -> ack low 2 cycles, no address skip.
REQ-026 Out-of-range address 0x400 with MEMORY_SIZE=1024:
- With BFM_MEMORY_WB_ERR_EN -> err 1, ack 0.
- Without it -> ack 1, access aliases to 0x000.
REQ-027 Reset pulse mid-burst:
- ack and err go to 0 at the next edge.
- Memory word written before the reset reads back unchanged.
